// File: rtl/uart_port_scheduler_pkg.sv
// Shared constants and state encoding for the UART port scheduler.
// Register offsets, status bit positions and the sequencer state type.
package uart_port_scheduler_pkg;

  localparam logic [7:0] UART_CTRL_OFS = 8'd0;
  localparam logic [7:0] UART_BUF_OFS  = 8'd1;
  localparam int         STAT_RX_FULL  = 0;
  localparam int         STAT_TX_EMPTY = 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_POLL_ISSUE = 3'd1,
    S_POLL_WAIT  = 3'd2,
    S_RX_ISSUE   = 3'd3,
    S_RX_WAIT    = 3'd4,
    S_TX_WRITE   = 3'd5
  } state_t;

endpackage

// File: rtl/uart_port_scheduler_if.sv
// Bus bundle between the scheduler, its TX requesters, its RX consumer and the UART.
// The master modport is the scheduler's view; slave is the surrounding environment.
interface uart_port_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic                   en;
  logic [NUM_REQ-1:0]     req_valid;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [7:0]             uart_address;
  logic [7:0]             uart_din;
  logic                   uart_w_en;
  logic                   uart_r_en;
  logic [7:0]             uart_dout;
  logic [1:0]             grant_id;
  logic                   busy;

  modport master (
    input  en, req_valid, req_data, rx_ready, uart_dout,
    output req_ready, rx_data, rx_valid, uart_address, uart_din,
           uart_w_en, uart_r_en, grant_id, busy
  );

  modport slave (
    output en, req_valid, req_data, rx_ready, uart_dout,
    input  req_ready, rx_data, rx_valid, uart_address, uart_din,
           uart_w_en, uart_r_en, grant_id, busy
  );
endinterface

// File: rtl/uart_port_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping modulo NUM_REQ.
// The pointer moves past the winner only when the caller strobes i_advance.
module uart_port_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [1:0]         o_idx,
  output logic               o_any
);

  logic [1:0] r_ptr;
  logic [3:0] w_req4;
  logic [2:0] w_sum;
  logic [1:0] w_pos;
  logic [1:0] w_idx;
  logic       w_found;

  assign w_req4 = 4'(i_req);

  always_comb begin
    w_found = 1'b0;
    w_idx   = 2'd0;
    w_sum   = 3'd0;
    w_pos   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr and k are both below NUM_REQ, so one conditional subtract wraps
      w_sum = {1'b0, r_ptr} + 3'(k);
      w_pos = (w_sum >= 3'(NUM_REQ)) ? 2'(w_sum - 3'(NUM_REQ)) : w_sum[1:0];
      if (!w_found && w_req4[w_pos]) begin
        w_found = 1'b1;
        w_idx   = w_pos;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign o_grant[gi] = w_found && (w_idx == 2'(gi));
  end

  assign o_idx = w_idx;
  assign o_any = w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_idx == 2'(NUM_REQ - 1)) ? 2'd0 : w_idx + 2'd1;
    end
  end

endmodule

// File: rtl/uart_port_scheduler.sv
// Sequencer owning the UART bus: polls status, drains RX bytes into a one-entry stream,
// and hands the transmitter to requesters in round-robin order.
module uart_port_scheduler #(
  parameter logic [7:0] UART_ADDRESS = 8'h00,
  parameter int         NUM_REQ      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_port_scheduler_if.master bus
);
  import uart_port_scheduler_pkg::*;

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_tx_hold;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic [1:0]         r_grant_id;
  logic               w_advance;
  logic [NUM_REQ-1:0] w_grant;
  logic [1:0]         w_idx;
  logic               w_any;
  logic [7:0]         w_req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
    assign w_req_byte[gi] = bus.req_data[8*gi +: 8];
  end

  uart_port_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (bus.req_valid),
    .i_advance (w_advance),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE:       if (bus.en) w_state_next = S_POLL_ISSUE;
      S_POLL_ISSUE: w_state_next = S_POLL_WAIT;
      S_POLL_WAIT: begin
        // Dropping en parks here: no RX read or TX grant is started after the poll
        if (!bus.en) begin
          w_state_next = S_IDLE;
        end else if (bus.uart_dout[STAT_RX_FULL] && !r_rx_valid) begin
          w_state_next = S_RX_ISSUE;
        end else if (bus.uart_dout[STAT_TX_EMPTY] && w_any) begin
          w_advance    = 1'b1;
          w_state_next = S_TX_WRITE;
        end else begin
          w_state_next = S_POLL_ISSUE;
        end
      end
      S_RX_ISSUE:   w_state_next = S_RX_WAIT;
      S_RX_WAIT:    w_state_next = bus.en ? S_POLL_ISSUE : S_IDLE;
      S_TX_WRITE:   w_state_next = bus.en ? S_POLL_ISSUE : S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_hold  <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_grant_id <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_advance) begin
        r_tx_hold  <= w_req_byte[w_idx];
        r_grant_id <= w_idx;
      end
      if (r_state == S_RX_WAIT) begin
        r_rx_data  <= bus.uart_dout;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.uart_r_en    = (r_state == S_POLL_ISSUE) || (r_state == S_RX_ISSUE);
  assign bus.uart_w_en    = (r_state == S_TX_WRITE);
  assign bus.uart_address = ((r_state == S_RX_ISSUE) || (r_state == S_TX_WRITE))
                            ? UART_ADDRESS + UART_BUF_OFS : UART_ADDRESS + UART_CTRL_OFS;
  assign bus.uart_din     = (r_state == S_TX_WRITE) ? r_tx_hold : 8'h00;
  assign bus.req_ready    = w_advance ? w_grant : '0;
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_port_scheduler.sv
// Self-checking bench for uart_port_scheduler with a behavioural UART register model
// and a write scoreboard of expected {requester, byte} pairs.
module tb_uart_port_scheduler;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  uart_port_scheduler_if #(.NUM_REQ(4)) bus ();

  uart_port_scheduler #(
    .UART_ADDRESS (8'h00),
    .NUM_REQ      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_status;
  logic [7:0] m_rx_byte;
  exp_t       exp_q[$];
  int         seq_len [4];
  int         seq_pos [4];
  logic [7:0] seq_base [4];

  logic [3:0] obs_ready;
  logic       obs_ren;
  logic       obs_wen;
  logic [7:0] obs_addr;
  logic [7:0] obs_din;
  logic [1:0] obs_gid;

  // UART register model: read data appears one cycle after r_en
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.uart_dout <= 8'h00;
    else if (bus.uart_r_en)
      bus.uart_dout <= (bus.uart_address == 8'h00) ? m_status : m_rx_byte;
  end

  task automatic sample();
    obs_ready = bus.req_ready;
    obs_ren   = bus.uart_r_en;
    obs_wen   = bus.uart_w_en;
    obs_addr  = bus.uart_address;
    obs_din   = bus.uart_din;
    obs_gid   = bus.grant_id;
  endtask

  // One clock: requesters react to the handshake seen before the edge, then sample at negedge
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (obs_ready[i] && bus.req_valid[i]) begin
        seq_pos[i]++;
        if (seq_pos[i] >= seq_len[i]) bus.req_valid[i] = 1'b0;
        else bus.req_data[8*i +: 8] = seq_base[i] + 8'(seq_pos[i]);
      end
    end
    @(negedge clk);
    sample();
  endtask

  task automatic set_req(input int i, input int n, input logic [7:0] base);
    seq_len[i]  = n;
    seq_pos[i]  = 0;
    seq_base[i] = base;
    bus.req_data[8*i +: 8] = base;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rx_ready  = 1'b0;
    m_status      = 8'h00;
    m_rx_byte     = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      seq_len[i] = 0; seq_pos[i] = 0; seq_base[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    sample();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.req_valid = '0; bus.req_data = '0;
    bus.rx_ready = 1'b0; m_status = 8'h00; m_rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample();
    checks++;
    if ({obs_ren, obs_wen, bus.busy, bus.rx_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: ren/wen/busy/rxv=%b required 0000", {obs_ren, obs_wen, bus.busy, bus.rx_valid});
    end
    checks++;
    if ({obs_addr, obs_din} !== 16'h0000) begin
      errors++; $display("FAIL reset_bus: addr/din=%h/%h required 00/00", obs_addr, obs_din);
    end
    checks++;
    if ({obs_ready, obs_gid, bus.rx_data} !== 14'h0) begin
      errors++; $display("FAIL reset_misc: ready=%b gid=%0d rx_data=%h required 0", obs_ready, obs_gid, bus.rx_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    sample();
    step(); step();
    checks++;
    if ({bus.busy, obs_ren} !== 2'b00) begin
      errors++; $display("FAIL reset_en0_idle: busy/ren=%b required 00", {bus.busy, obs_ren});
    end
    bus.en = 1'b1;
    #1 sample();
    checks++;
    if (obs_ren !== 1'b0) begin
      errors++; $display("FAIL reset_before_first: ren=%b required 0", obs_ren);
    end
    step();
    checks++;
    if ({obs_ren, obs_wen, obs_addr} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL reset_first_access: ren/wen=%b addr=%h required 10/00", {obs_ren, obs_wen}, obs_addr);
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_single_tx();
    exp_t e;
    int   rdy_cyc;
    apply_reset();
    m_status = 8'h02;
    set_req(0, 1, 8'hA5);
    push_exp(2'd0, 8'hA5);
    bus.en = 1'b1;
    #1 sample();
    rdy_cyc = -10;
    for (int c = 0; c < 30; c++) begin
      step();
      if (obs_ready != 4'b0000) begin
        checks++;
        if (obs_ready !== 4'b0001) begin
          errors++; $display("FAIL single_ready: req_ready=%b required 0001", obs_ready);
        end
        rdy_cyc = c;
      end
      if (obs_wen) begin
        checks++;
        if (c != rdy_cyc + 1) begin
          errors++; $display("FAIL single_latency: write at cycle %0d, ready at %0d, required ready+1", c, rdy_cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL single_extra_write: din=%h required no write", obs_din);
        end else begin
          e = exp_q.pop_front();
          if ({obs_addr, obs_din, obs_gid} !== {8'h01, e.data, e.id}) begin
            errors++; $display("FAIL single_write: addr/din/gid=%h/%h/%0d required 01/%h/%0d", obs_addr, obs_din, obs_gid, e.data, e.id);
          end
        end
        $display("single_tx write: addr=%h din=%h gid=%0d", obs_addr, obs_din, obs_gid);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL single_timeout: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    apply_reset();
    m_status = 8'h02;
    set_req(0, 2, 8'h10);
    set_req(1, 1, 8'h20);
    set_req(2, 1, 8'h30);
    set_req(3, 1, 8'h40);
    push_exp(2'd0, 8'h10); push_exp(2'd1, 8'h20); push_exp(2'd2, 8'h30);
    push_exp(2'd3, 8'h40); push_exp(2'd0, 8'h11);
    bus.en = 1'b1;
    #1 sample();
    for (int c = 0; c < 40; c++) begin
      step();
      if (obs_wen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rr_extra_write: din=%h required no write", obs_din);
        end else begin
          e = exp_q.pop_front();
          if ({obs_addr, obs_din, obs_gid} !== {8'h01, e.data, e.id}) begin
            errors++; $display("FAIL rr_write: addr/din/gid=%h/%h/%0d required 01/%h/%0d", obs_addr, obs_din, obs_gid, e.data, e.id);
          end
        end
        $display("round_robin write: din=%h gid=%0d", obs_din, obs_gid);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_timeout: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_rx_priority();
    exp_t e;
    int   rd_cnt;
    int   rd_cyc;
    apply_reset();
    m_status  = 8'h03;
    m_rx_byte = 8'h3C;
    set_req(1, 1, 8'h5A);
    push_exp(2'd1, 8'h5A);
    bus.en = 1'b1;
    #1 sample();
    rd_cnt = 0;
    rd_cyc = -10;
    for (int c = 0; c < 30; c++) begin
      step();
      if (obs_ren && obs_addr == 8'h01) begin
        rd_cnt++; rd_cyc = c;
        $display("rx_priority buffer read at cycle %0d", c);
      end
      if (c == rd_cyc + 2) begin
        checks++;
        if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h3C}) begin
          errors++; $display("FAIL rx_load: rx_valid/rx_data=%b/%h required 1/3c", bus.rx_valid, bus.rx_data);
        end
      end
      if (obs_wen) begin
        checks++;
        if (rd_cnt !== 1) begin
          errors++; $display("FAIL rx_before_tx: buffer reads before write=%0d required 1", rd_cnt);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rx_extra_write: din=%h required no write", obs_din);
        end else begin
          e = exp_q.pop_front();
          if ({obs_addr, obs_din, obs_gid} !== {8'h01, e.data, e.id}) begin
            errors++; $display("FAIL rx_tx_write: addr/din/gid=%h/%h/%0d required 01/%h/%0d", obs_addr, obs_din, obs_gid, e.data, e.id);
          end
        end
        $display("rx_priority write: din=%h gid=%0d", obs_din, obs_gid);
      end
    end
    checks++;
    if (rd_cnt != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL rx_prio_totals: reads=%0d missing_writes=%0d required 1/0", rd_cnt, exp_q.size());
    end
  endtask

  task automatic test_rx_backpressure();
    int  rd_cnt;
    logic seen;
    apply_reset();
    m_status  = 8'h01;
    m_rx_byte = 8'h11;
    bus.en = 1'b1;
    for (int c = 0; c < 20 && !bus.rx_valid; c++) step();
    checks++;
    if (bus.rx_valid !== 1'b1) begin
      errors++; $display("FAIL bp_first_fill: rx_valid=%b required 1", bus.rx_valid);
    end
    m_rx_byte = 8'h22;
    rd_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (obs_ren && obs_addr == 8'h01) rd_cnt++;
    end
    checks++;
    if (rd_cnt != 0) begin
      errors++; $display("FAIL bp_no_read: buffer reads=%0d required 0", rd_cnt);
    end
    checks++;
    if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL bp_hold: rx_valid/rx_data=%b/%h required 1/11", bus.rx_valid, bus.rx_data);
    end
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    checks++;
    if (bus.rx_valid !== 1'b0) begin
      errors++; $display("FAIL bp_consume: rx_valid=%b required 0", bus.rx_valid);
    end
    seen = obs_ren && (obs_addr == 8'h01);
    for (int c = 0; c < 2 && !seen; c++) begin
      step();
      seen = obs_ren && (obs_addr == 8'h01);
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL bp_read_after_consume: buffer read within 3 cycles=%b required 1", seen);
    end
    for (int c = 0; c < 5 && !bus.rx_valid; c++) step();
    checks++;
    if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h22}) begin
      errors++; $display("FAIL bp_refill: rx_valid/rx_data=%b/%h required 1/22", bus.rx_valid, bus.rx_data);
    end
    $display("rx_backpressure done: rx_data=%h", bus.rx_data);
  endtask

  task automatic test_en_and_async_reset();
    exp_t e;
    int   acc;
    logic found;
    apply_reset();
    m_status = 8'h02;
    set_req(2, 1, 8'hC3);
    push_exp(2'd2, 8'hC3);
    bus.en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (obs_wen) begin
        found = 1'b1;
        bus.en = 1'b0;
        checks++;
        e = exp_q.pop_front();
        if ({obs_addr, obs_din, obs_gid} !== {8'h01, e.data, e.id}) begin
          errors++; $display("FAIL en_write: addr/din/gid=%h/%h/%0d required 01/%h/%0d", obs_addr, obs_din, obs_gid, e.data, e.id);
        end
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL en_timeout: write seen=%b required 1", found);
    end
    step();
    checks++;
    if ({bus.busy, obs_ren, obs_wen} !== 3'b000) begin
      errors++; $display("FAIL en_park: busy/ren/wen=%b required 000", {bus.busy, obs_ren, obs_wen});
    end
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_ren || obs_wen || bus.busy) acc++;
    end
    checks++;
    if (acc != 0 || obs_gid !== 2'd2) begin
      errors++; $display("FAIL en_idle_hold: activity=%0d gid=%0d required 0/2", acc, obs_gid);
    end

    apply_reset();
    m_status  = 8'h01;
    m_rx_byte = 8'h77;
    bus.en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (obs_ren && obs_addr == 8'h01) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL arst_timeout: rx_issue seen=%b required 1", found);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.uart_r_en, bus.busy, bus.rx_valid, bus.uart_address} !== {3'b000, 8'h00}) begin
      errors++; $display("FAIL arst_drop: ren/busy/rxv=%b addr=%h required 000/00",
                         {bus.uart_r_en, bus.busy, bus.rx_valid}, bus.uart_address);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("en_and_async_reset done: errors=%0d", errors);
  endtask

  initial begin
    rst_n = 1'b0;
    obs_ready = '0; obs_ren = 1'b0; obs_wen = 1'b0;
    obs_addr = 8'h00; obs_din = 8'h00; obs_gid = 2'd0;
    test_reset();
    test_single_tx();
    test_round_robin();
    test_rx_priority();
    test_rx_backpressure();
    test_en_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
